// File: rtl/bpf_defs.sv
// Shared BPF encodings, instruction field positions and the decoded-opcode
// bundle used by the decode, execute and writeback stages.
package bpf_defs;

    typedef enum logic [2:0] {
        CLS_LD, CLS_LDX, CLS_ST, CLS_STX, CLS_ALU, CLS_JMP, CLS_RET, CLS_MISC
    } bpf_cls_e;

    typedef enum logic [1:0] {SIZE_W, SIZE_H, SIZE_B} bpf_size_e;

    typedef enum logic [2:0] {
        MODE_IMM, MODE_ABS, MODE_IND, MODE_MEM, MODE_LEN, MODE_MSH
    } bpf_mode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_OR, ALU_AND,
        ALU_LSH, ALU_RSH, ALU_NEG, ALU_MOD, ALU_XOR
    } bpf_alu_e;

    typedef enum logic [2:0] {JMP_JA, JMP_JEQ, JMP_JGT, JMP_JGE, JMP_JSET} bpf_jmp_e;

    typedef enum logic [1:0] {RET_K, RET_X, RET_A} bpf_ret_e;

    // Bit positions inside the 64-bit instruction word.
    localparam int OPC_LSB = 48;
    localparam int JT_LSB  = 40;
    localparam int JF_LSB  = 32;
    localparam int K_LSB   = 0;

    typedef struct packed {
        logic [2:0] cls;
        logic [1:0] size;
        logic [2:0] mode;
        logic [3:0] alu_op;
        logic [2:0] jmp_op;
        logic       src_x;
        logic [1:0] ret_src;
        logic       misc_txa;
        logic       illegal;
    } bpf_dec_t;

endpackage

// File: rtl/bpf_decode.sv
// Combinational opcode decoder: splits a 16-bit BPF opcode into its
// overlapping field views and flags encodings that are not legal BPF.
module bpf_decode
    import bpf_defs::*;
(
    input  logic [15:0] opcode,
    output bpf_dec_t    dec
);

    always_comb begin
        dec          = '0;
        dec.cls      = opcode[2:0];
        dec.size     = opcode[4:3];
        dec.mode     = opcode[7:5];
        dec.alu_op   = opcode[7:4];
        dec.jmp_op   = opcode[6:4];
        dec.src_x    = opcode[3];
        dec.ret_src  = opcode[4:3];
        dec.misc_txa = opcode[7];

        case (opcode[2:0])
            CLS_LD, CLS_LDX: dec.illegal = (opcode[7:5] > MODE_MSH) || (opcode[4:3] == 2'd3);
            CLS_ALU:         dec.illegal = (opcode[7:4] > ALU_XOR);
            CLS_JMP:         dec.illegal = (opcode[6:4] > JMP_JSET);
            CLS_RET:         dec.illegal = (opcode[4:3] == 2'd3);
            default:         dec.illegal = 1'b0;
        endcase

        // The upper opcode byte is reserved in every class.
        if (opcode[15:8] != 8'd0) begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/stage1.sv
// Decode stage: registers one fetched instruction with its decoded fields
// and hands it to execute over a valid/ready handshake; flushed on mispredict.
module stage1
    import bpf_defs::*;
#(
    parameter int PC_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_mispredict,
    input  logic [63:0]         instr_in,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic                prev_vld,
    output logic                rdy,
    input  logic                next_rdy,
    output logic                vld,
    output logic [2:0]          cls,
    output logic [1:0]          size,
    output logic [2:0]          mode,
    output logic [3:0]          alu_op,
    output logic [2:0]          jmp_op,
    output logic                src_x,
    output logic [1:0]          ret_src,
    output logic                misc_txa,
    output logic [7:0]          jt,
    output logic [7:0]          jf,
    output logic [31:0]         imm,
    output logic [PC_WIDTH-1:0] pc,
    output logic                illegal
);

    bpf_dec_t            dec_next;
    bpf_dec_t            dec_reg;
    logic                vld_reg;
    logic [7:0]          jt_reg;
    logic [7:0]          jf_reg;
    logic [31:0]         imm_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic                capture;

    bpf_decode u_decode (
        .opcode (instr_in[OPC_LSB +: 16]),
        .dec    (dec_next)
    );

    // Ready never looks at prev_vld, so there is no combinational loop with fetch.
    assign rdy     = !vld_reg || next_rdy;
    assign capture = prev_vld && rdy && !branch_mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= 1'b0;
            dec_reg <= '0;
            jt_reg  <= '0;
            jf_reg  <= '0;
            imm_reg <= '0;
            pc_reg  <= '0;
        end else if (branch_mispredict) begin
            vld_reg <= 1'b0;
        end else if (capture) begin
            vld_reg <= 1'b1;
            dec_reg <= dec_next;
            jt_reg  <= instr_in[JT_LSB +: 8];
            jf_reg  <= instr_in[JF_LSB +: 8];
            imm_reg <= instr_in[K_LSB +: 32];
            pc_reg  <= pc_in;
        end else if (next_rdy) begin
            vld_reg <= 1'b0;
        end
    end

    assign vld      = vld_reg;
    assign cls      = dec_reg.cls;
    assign size     = dec_reg.size;
    assign mode     = dec_reg.mode;
    assign alu_op   = dec_reg.alu_op;
    assign jmp_op   = dec_reg.jmp_op;
    assign src_x    = dec_reg.src_x;
    assign ret_src  = dec_reg.ret_src;
    assign misc_txa = dec_reg.misc_txa;
    assign illegal  = dec_reg.illegal;
    assign jt       = jt_reg;
    assign jf       = jf_reg;
    assign imm      = imm_reg;
    assign pc       = pc_reg;

endmodule

// File: tb/tb_stage1.sv
// Self-checking bench for stage1: directed cases plus a randomized stream
// compared against a behavioural slot model and an in-order scoreboard.
module tb_stage1;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          branch_mispredict;
    logic [63:0]   instr_in;
    logic [PW-1:0] pc_in;
    logic          prev_vld;
    logic          rdy;
    logic          next_rdy;
    logic          vld;
    logic [2:0]    cls;
    logic [1:0]    size;
    logic [2:0]    mode;
    logic [3:0]    alu_op;
    logic [2:0]    jmp_op;
    logic          src_x;
    logic [1:0]    ret_src;
    logic          misc_txa;
    logic [7:0]    jt;
    logic [7:0]    jf;
    logic [31:0]   imm;
    logic [PW-1:0] pc;
    logic          illegal;

    stage1 #(.PC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
        .instr_in(instr_in), .pc_in(pc_in), .prev_vld(prev_vld), .rdy(rdy),
        .next_rdy(next_rdy), .vld(vld), .cls(cls), .size(size), .mode(mode),
        .alu_op(alu_op), .jmp_op(jmp_op), .src_x(src_x), .ret_src(ret_src),
        .misc_txa(misc_txa), .jt(jt), .jf(jf), .imm(imm), .pc(pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: what the single slot should hold.
    logic          m_vld;
    logic [63:0]   m_instr;
    logic [PW-1:0] m_pc;
    logic          m_clean;
    logic [PW-1:0] sb_q[$];
    int            delivered;

    function automatic bit ref_illegal(input int op);
        int c, md, sz, ao, jo, rs;
        c  = op % 8;
        sz = (op / 8) % 4;
        md = (op / 32) % 8;
        ao = (op / 16) % 16;
        jo = (op / 16) % 8;
        rs = sz;
        if (op >= 256) return 1;
        if ((c == 0 || c == 1) && (md > 5 || sz == 3)) return 1;
        if (c == 4 && ao > 10) return 1;
        if (c == 5 && jo > 4) return 1;
        if (c == 6 && rs == 3) return 1;
        return 0;
    endfunction

    task automatic check_outputs(input string tag);
        int op;
        op = int'(m_instr[63:48]);
        chk({tag, ".vld"}, 64'(vld), 64'(m_vld));
        chk({tag, ".rdy"}, 64'(rdy), 64'(!m_vld || next_rdy));
        if (m_vld || m_clean) begin
            chk({tag, ".cls"},     64'(cls),      64'(op % 8));
            chk({tag, ".size"},    64'(size),     64'((op / 8) % 4));
            chk({tag, ".mode"},    64'(mode),     64'((op / 32) % 8));
            chk({tag, ".alu_op"},  64'(alu_op),   64'((op / 16) % 16));
            chk({tag, ".jmp_op"},  64'(jmp_op),   64'((op / 16) % 8));
            chk({tag, ".src_x"},   64'(src_x),    64'((op / 8) % 2));
            chk({tag, ".ret_src"}, 64'(ret_src),  64'((op / 8) % 4));
            chk({tag, ".txa"},     64'(misc_txa), 64'((op / 128) % 2));
            chk({tag, ".jt"},      64'(jt),       64'(m_instr[47:40]));
            chk({tag, ".jf"},      64'(jf),       64'(m_instr[39:32]));
            chk({tag, ".imm"},     64'(imm),      64'(m_instr[31:0]));
            chk({tag, ".pc"},      64'(pc),       64'(m_pc));
            chk({tag, ".illegal"}, 64'(illegal),  64'(m_clean ? 1'b0 : ref_illegal(op)));
        end
    endtask

    // One clock: scoreboard the outgoing transfer, advance the model, check.
    task automatic cycle(input string tag, output bit took);
        bit in_x, out_x;
        in_x  = prev_vld && (!m_vld || next_rdy) && !branch_mispredict && !rst;
        out_x = m_vld && next_rdy && !rst;
        took  = in_x;
        if (out_x) begin
            if (sb_q.size() == 0) chk({tag, ".sb_empty"}, 64'(pc), 64'hdead);
            else chk({tag, ".sb_pc"}, 64'(pc), 64'(sb_q.pop_front()));
            delivered++;
            $display("deliver pc=%0d cls=%0d illegal=%0d", pc, cls, illegal);
        end
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_instr = '0; m_pc = '0; m_clean = 1; sb_q.delete();
        end else if (branch_mispredict) begin
            m_vld = 0; sb_q.delete();
        end else if (in_x) begin
            m_vld = 1; m_instr = instr_in; m_pc = pc_in; m_clean = 0;
            sb_q.push_back(pc_in);
        end else if (out_x) begin
            m_vld = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [63:0] mk(input logic [15:0] op, input logic [7:0] t,
                                       input logic [7:0] f, input logic [31:0] k);
        return {op, t, f, k};
    endfunction

    bit took;
    logic [15:0] rop;

    initial begin
        m_vld = 0; m_instr = '0; m_pc = '0; m_clean = 1; delivered = 0;
        rst = 1; branch_mispredict = 0; next_rdy = 1; prev_vld = 1;
        instr_in = 64'h1234_5678_9abc_def0; pc_in = 10'd77;
        #1;
        cycle("reset0", took);
        cycle("reset1", took);
        rst = 0; prev_vld = 0;
        chk("reset.rdy_after", 64'(rdy), 64'd1);

        // ALU ADD X
        prev_vld = 1; instr_in = 64'h000C_0000_0000_0000; pc_in = 10'd5;
        cycle("alu_add_x", took);
        chk("alu.cls", 64'(cls), 64'd4);
        chk("alu.src_x", 64'(src_x), 64'd1);
        chk("alu.pc", 64'(pc), 64'd5);

        // Backpressure on JEQ K
        instr_in = mk(16'h0015, 8'd3, 8'd7, 32'h0800); pc_in = 10'd6;
        cycle("jeq_cap", took);
        next_rdy = 0; instr_in = mk(16'h0006, 8'd1, 8'd1, 32'h1); pc_in = 10'd7;
        for (int i = 0; i < 4; i++) cycle("stall", took);
        chk("stall.rdy", 64'(rdy), 64'd0);
        chk("stall.jf", 64'(jf), 64'd7);
        next_rdy = 1; prev_vld = 0;
        cycle("release", took);
        chk("release.vld", 64'(vld), 64'd0);

        // Mispredict during capture, then mispredict while stalled
        prev_vld = 1; branch_mispredict = 1;
        cycle("mp_capture", took);
        branch_mispredict = 0; pc_in = 10'd8;
        cycle("mp_fill", took);
        next_rdy = 0; branch_mispredict = 1;
        cycle("mp_stalled", took);
        chk("mp.vld", 64'(vld), 64'd0);
        branch_mispredict = 0; next_rdy = 1;

        // Illegal encodings
        instr_in = mk(16'h00B4, 8'd0, 8'd0, 32'd0); pc_in = 10'd9;
        cycle("ill_alu11", took);
        chk("ill_alu11.illegal", 64'(illegal), 64'd1);
        instr_in = mk(16'h0016, 8'd0, 8'd0, 32'd42); pc_in = 10'd10;
        cycle("ret_a", took);
        chk("ret_a.ret_src", 64'(ret_src), 64'd2);
        chk("ret_a.illegal", 64'(illegal), 64'd0);
        instr_in = mk(16'h0100, 8'd0, 8'd0, 32'd0); pc_in = 10'd11;
        cycle("ill_hi", took);
        chk("ill_hi.illegal", 64'(illegal), 64'd1);

        // Reset while stalled discards the held instruction
        next_rdy = 0; prev_vld = 0;
        cycle("pre_rst_stall", took);
        rst = 1;
        cycle("rst_stall", took);
        chk("rst_stall.vld", 64'(vld), 64'd0);
        rst = 0;

        // Randomized stream of 16 with random downstream backpressure
        delivered = 0;
        begin
            int sent = 0;
            int budget = 0;
            prev_vld = 1;
            rop = 16'($urandom_range(0, 255));
            instr_in = {rop, 32'($urandom), 16'($urandom)}; pc_in = 10'd100;
            while (sent < 16 && budget < 400) begin
                next_rdy = 1'($urandom);
                cycle("stream", took);
                budget++;
                if (took) begin
                    sent++;
                    rop = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                    instr_in = {rop, 32'($urandom), 16'($urandom)};
                    pc_in = pc_in + 10'd1;
                end
            end
            prev_vld = 0; next_rdy = 1;
            for (int i = 0; i < 3; i++) cycle("drain", took);
            chk("stream.sent", 64'(sent), 64'd16);
            chk("stream.delivered", 64'(delivered), 64'd16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
